// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the single-port 1RW memory bank with registered read return.
package mem_bank_pkg;

  localparam int unsigned PAR_MAXW = 1024;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } bank_state_e;

  // Stored word width: one extra MSB when parity is enabled.
  function automatic int unsigned memwdth_f(input int unsigned width, input int unsigned enapar);
    return (enapar != 0) ? width + 1 : width;
  endfunction

  // Even parity over a word zero-extended to PAR_MAXW; zero padding leaves the XOR unchanged.
  function automatic logic parity_f(input logic [PAR_MAXW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read return pipeline; data/padr hold their last returned value between reads.
module mem_rd_pipe #(
  parameter int unsigned DW    = 33,
  parameter int unsigned AW    = 11,
  parameter int unsigned DELAY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  input  logic          i_fwd,
  input  logic          i_serr,
  input  logic [AW-1:0] i_padr,
  output logic [DW-1:0] o_dat,
  output logic          o_fwd,
  output logic          o_serr,
  output logic [AW-1:0] o_padr
);

  logic [DELAY-1:0]         w_ld;
  logic [DELAY-1:0][DW-1:0] r_dat;
  logic [DELAY-1:0][AW-1:0] r_padr;
  logic [DELAY-1:0]         r_fwd;
  logic [DELAY-1:0]         r_serr;

  // Load enable of each stage is the valid bit of the stage feeding it.
  generate
    if (DELAY > 1) begin : g_vld
      logic [DELAY-2:0] r_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= i_vld;
          for (int unsigned s = 1; s < DELAY - 1; s++) begin
            r_vld[s] <= r_vld[s-1];
          end
        end
      end

      assign w_ld = {r_vld, i_vld};
    end else begin : g_novld
      assign w_ld = i_vld;
    end
  endgenerate

  // fwd/serr are gated by valid at entry, so they read 0 in cycles without a return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat  <= '0;
      r_padr <= '0;
      r_fwd  <= '0;
      r_serr <= '0;
    end else begin
      r_fwd[0]  <= i_vld & i_fwd;
      r_serr[0] <= i_vld & i_serr;
      if (w_ld[0]) begin
        r_dat[0]  <= i_dat;
        r_padr[0] <= i_padr;
      end
      for (int unsigned s = 1; s < DELAY; s++) begin
        r_fwd[s]  <= r_fwd[s-1];
        r_serr[s] <= r_serr[s-1];
        if (w_ld[s]) begin
          r_dat[s]  <= r_dat[s-1];
          r_padr[s] <= r_padr[s-1];
        end
      end
    end
  end

  assign o_dat  = r_dat[DELAY-1];
  assign o_padr = r_padr[DELAY-1];
  assign o_fwd  = r_fwd[DELAY-1];
  assign o_serr = r_serr[DELAY-1];

endmodule

// File: rtl/mem_1rw_bank_rsp.sv
// 1RW memory bank: zero-fill INIT after reset, one-entry write buffer with read forwarding,
// parity check on return, error injection and sticky read/write collision flag.
module mem_1rw_bank_rsp
  import mem_bank_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BITWDTH    = 5,
  parameter int unsigned ENAPAR     = 0,
  parameter int unsigned MEMWDTH    = memwdth_f(WIDTH, ENAPAR),
  parameter int unsigned NUMVROW    = 1024,
  parameter int unsigned BITVROW    = 10,
  parameter int unsigned BITPADR    = 15,
  parameter int unsigned BITPBNK    = 4,
  parameter int unsigned SRAM_DELAY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         readA,
  input  logic                         writeA,
  input  logic [BITVROW-1:0]           addrA,
  input  logic [MEMWDTH-1:0]           dinA,
  output logic [MEMWDTH-1:0]           doutA,
  output logic                         fwrdA,
  output logic                         serrA,
  output logic                         derrA,
  output logic [BITPADR-BITPBNK-1:0]   padrA,
  output logic                         ready,
  input  logic                         inj_vld,
  input  logic [BITVROW-1:0]           inj_adr,
  input  logic [BITWDTH-1:0]           inj_bit,
  output logic                         coll_err
);

  localparam int unsigned PADRW = BITPADR - BITPBNK;

  bank_state_e          r_state;
  bank_state_e          w_state_nxt;
  logic [BITVROW-1:0]   r_init_cnt;
  logic [BITVROW-1:0]   w_init_cnt_nxt;
  logic                 r_ready;
  logic                 r_coll;

  logic                 r_wb_vld;
  logic [BITVROW-1:0]   r_wb_adr;
  logic [MEMWDTH-1:0]   r_wb_dat;

  logic [MEMWDTH-1:0]   r_mem [NUMVROW];

  logic                 w_idle;
  logic                 w_init_we;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_coll;
  logic                 w_inj_en;
  logic [MEMWDTH-1:0]   w_inj_mask;
  logic [MEMWDTH-1:0]   w_inj_base;
  logic                 w_rd_fwd;
  logic [MEMWDTH-1:0]   w_rd_dat;
  logic                 w_rd_serr;

  // FSM state register, INIT row counter, ready and sticky collision flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
      r_coll     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_ready    <= (w_state_nxt == IDLE);
      if (w_coll) begin
        r_coll <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_init_we      = 1'b0;
    case (r_state)
      INIT: begin
        w_init_we      = 1'b1;
        w_init_cnt_nxt = r_init_cnt + BITVROW'(1);
        if (r_init_cnt == BITVROW'(NUMVROW - 1)) begin
          w_state_nxt    = IDLE;
          w_init_cnt_nxt = '0;
        end
      end
      IDLE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  // Request qualification: a write wins over a simultaneous read.
  always_comb begin
    w_idle     = (r_state == IDLE);
    w_wr_acc   = w_idle & writeA;
    w_rd_acc   = w_idle & readA & ~writeA;
    w_coll     = w_idle & readA & writeA;
    w_inj_en   = w_idle & inj_vld & (32'(inj_bit) < MEMWDTH);
    w_inj_mask = MEMWDTH'(1) << inj_bit;
    w_inj_base = (r_wb_vld && (r_wb_adr == inj_adr)) ? r_wb_dat : r_mem[inj_adr];
    w_rd_fwd   = r_wb_vld && (r_wb_adr == addrA);
    w_rd_dat   = w_rd_fwd ? r_wb_dat : r_mem[addrA];
    w_rd_serr  = (ENAPAR != 0) ? parity_f(PAR_MAXW'(w_rd_dat)) : 1'b0;
  end

  // One-entry write buffer; its content commits on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_vld <= 1'b0;
      r_wb_adr <= '0;
      r_wb_dat <= '0;
    end else begin
      r_wb_vld <= w_wr_acc;
      if (w_wr_acc) begin
        r_wb_adr <= addrA;
        r_wb_dat <= dinA;
      end
    end
  end

  // Array: INIT zero-fill, buffer commit, then injection layered on top of any same-row commit.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_init_cnt] <= '0;
    end
    if (r_wb_vld) begin
      r_mem[r_wb_adr] <= r_wb_dat;
    end
    if (w_inj_en) begin
      r_mem[inj_adr] <= w_inj_base ^ w_inj_mask;
    end
  end

  mem_rd_pipe #(
    .DW    (MEMWDTH),
    .AW    (PADRW),
    .DELAY (SRAM_DELAY)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst),
    .i_vld  (w_rd_acc),
    .i_dat  (w_rd_dat),
    .i_fwd  (w_rd_fwd),
    .i_serr (w_rd_serr),
    .i_padr (PADRW'(addrA)),
    .o_dat  (doutA),
    .o_fwd  (fwrdA),
    .o_serr (serrA),
    .o_padr (padrA)
  );

  assign derrA    = 1'b0;
  assign ready    = r_ready;
  assign coll_err = r_coll;

endmodule
